// File: rtl/frame_sink.sv
// frame_sink: serial frame decoder for the backscatter tag data link.
// It samples the line once per bit, hunts for the preamble, collects the
// triplicated MAC payload, majority-votes it and reports the MAC word.
module frame_sink #(
    parameter int unsigned BIT_PERIOD    = 50,
    parameter int unsigned SAMPLE_POINT  = 25,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'h92
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic        rx_bit,
    output logic [15:0] mac_data,
    output logic        mac_valid,
    output logic        mac_error,
    output logic        corrected,
    output logic        in_frame
);

    localparam int unsigned CNT_W  = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned PRE_W  = 48;
    localparam int unsigned PAY_W  = 96;
    localparam int unsigned FILL_W = 6;
    localparam int unsigned IDX_W  = 7;
    localparam logic [PRE_W-1:0] PREAMBLE = {6{PREAMBLE_BYTE}};

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DECIDE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PRE_W-1:0]    r_shift;
    logic [FILL_W-1:0]   r_fill;
    logic [IDX_W-1:0]    r_idx;
    logic [PAY_W-1:0]    r_payload;

    logic                w_sample;
    logic [PRE_W-1:0]    w_shift_next;
    logic [FILL_W-1:0]   w_fill_next;
    logic                w_lock;
    logic [7:0]          w_hi_a;
    logic [7:0]          w_lo_a;
    logic [7:0]          w_hi_b;
    logic [7:0]          w_lo_b;
    logic                w_unanimous;

    // Bitwise two-of-three vote over one byte triple
    function automatic logic [7:0] maj8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when all three copies of a byte agree
    function automatic logic same3(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c);
        return (a == b) && (b == c);
    endfunction

    // Bit-period counter: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge clock) begin
        if (reset || !trigger) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(BIT_PERIOD - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_sample     = trigger && (r_cnt == CNT_W'(SAMPLE_POINT));
    assign w_shift_next = {r_shift[PRE_W-2:0], rx_bit};
    assign w_fill_next  = (r_fill == FILL_W'(PRE_W)) ? r_fill : r_fill + FILL_W'(1);
    assign w_lock       = (w_fill_next == FILL_W'(PRE_W)) && (w_shift_next == PREAMBLE);

    // Payload bytes c0..c11 sit MSB-first, c0 in the top byte
    assign w_hi_a = maj8(r_payload[95:88], r_payload[87:80], r_payload[79:72]);
    assign w_lo_a = maj8(r_payload[71:64], r_payload[63:56], r_payload[55:48]);
    assign w_hi_b = maj8(r_payload[47:40], r_payload[39:32], r_payload[31:24]);
    assign w_lo_b = maj8(r_payload[23:16], r_payload[15:8],  r_payload[7:0]);
    assign w_unanimous = same3(r_payload[95:88], r_payload[87:80], r_payload[79:72])
                      && same3(r_payload[71:64], r_payload[63:56], r_payload[55:48])
                      && same3(r_payload[47:40], r_payload[39:32], r_payload[31:24])
                      && same3(r_payload[23:16], r_payload[15:8],  r_payload[7:0]);

    // Frame FSM: hunt for preamble, collect payload, vote and report
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_HUNT;
            r_shift   <= '0;
            r_fill    <= '0;
            r_idx     <= '0;
            r_payload <= '0;
            mac_data  <= '0;
            mac_valid <= 1'b0;
            mac_error <= 1'b0;
            corrected <= 1'b0;
            in_frame  <= 1'b0;
        end else begin
            mac_valid <= 1'b0;
            mac_error <= 1'b0;
            if (!trigger) begin
                r_state  <= S_HUNT;
                r_shift  <= '0;
                r_fill   <= '0;
                r_idx    <= '0;
                in_frame <= 1'b0;
            end else begin
                case (r_state)
                    S_HUNT: begin
                        if (w_sample) begin
                            r_shift <= w_shift_next;
                            r_fill  <= w_fill_next;
                            if (w_lock) begin
                                r_state  <= S_PAYLOAD;
                                r_idx    <= '0;
                                in_frame <= 1'b1;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_sample) begin
                            r_payload <= {r_payload[PAY_W-2:0], rx_bit};
                            r_idx     <= r_idx + IDX_W'(1);
                            if (r_idx == IDX_W'(PAY_W - 1)) begin
                                r_state <= S_DECIDE;
                            end
                        end
                    end
                    S_DECIDE: begin
                        if ({w_hi_a, w_lo_a} == {w_hi_b, w_lo_b}) begin
                            mac_data  <= {w_hi_a, w_lo_a};
                            mac_valid <= 1'b1;
                            corrected <= !w_unanimous;
                        end else begin
                            mac_error <= 1'b1;
                        end
                        r_state  <= S_HUNT;
                        r_shift  <= '0;
                        r_fill   <= '0;
                        in_frame <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_HUNT;
                        in_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_sink.sv
// tb_frame_sink: table-driven and randomized checks of frame_sink against
// a bit-stream reference model.
module tb_frame_sink;

    localparam int BP = 10;
    localparam int SP = 5;
    localparam logic [7:0] PRE = 8'h92;

    logic        clock;
    logic        reset;
    logic        trigger;
    logic        rx_bit;
    logic [15:0] mac_data;
    logic        mac_valid;
    logic        mac_error;
    logic        corrected;
    logic        in_frame;

    frame_sink #(
        .BIT_PERIOD   (BP),
        .SAMPLE_POINT (SP),
        .PREAMBLE_BYTE(PRE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .trigger  (trigger),
        .rx_bit   (rx_bit),
        .mac_data (mac_data),
        .mac_valid(mac_valid),
        .mac_error(mac_error),
        .corrected(corrected),
        .in_frame (in_frame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          edge_n;
        bit          is_err;
        logic [15:0] data;
        logic        corr;
    } ev_t;

    typedef struct {
        logic [15:0]       mac;
        int                pre_kind;
        logic [11:0][7:0]  flip;
        int                n_valid;
        int                n_err;
        logic [15:0]       data;
        logic              corr;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    edge_cnt = 0;
    bit    prev_pulse = 0;
    logic  prev_if = 0;
    int    pt;

    bit    stim_q[$];
    ev_t   act_ev_q[$];
    ev_t   exp_ev_q[$];
    int    act_lock_q[$];
    int    exp_lock_q[$];
    int    act_fall_q[$];

    logic [15:0] mdl_data = '0;
    logic        mdl_corr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: logs pulses and in_frame edges, labelled by posedge number
    always @(posedge clock) begin
        #1;
        edge_cnt++;
        if (mac_valid || mac_error) begin
            ev_t ev;
            ev.edge_n = edge_cnt;
            ev.is_err = mac_error;
            ev.data   = mac_data;
            ev.corr   = corrected;
            act_ev_q.push_back(ev);
            chk("pulse_exclusive", 32'(mac_valid && mac_error), 32'd0);
            chk("pulse_spacing", 32'(prev_pulse), 32'd0);
        end
        prev_pulse = mac_valid || mac_error;
        if (in_frame && !prev_if) act_lock_q.push_back(edge_cnt);
        if (!in_frame && prev_if) act_fall_q.push_back(edge_cnt);
        prev_if = in_frame;
    end

    task automatic clear_logs();
        act_ev_q.delete();
        act_lock_q.delete();
        act_fall_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stim_q.push_back(b[i]);
    endtask

    task automatic build_frame(input logic [15:0] mac, input logic [11:0][7:0] flip,
                               input int pre_kind, input int noise);
        stim_q.delete();
        for (int i = 0; i < noise; i++) stim_q.push_back(1'($urandom_range(0, 1)));
        if (pre_kind == 1) begin
            for (int i = 0; i < 5; i++) push_byte(PRE);
            push_byte(8'h00);
        end
        for (int i = 0; i < 6; i++) push_byte(PRE);
        for (int k = 0; k < 12; k++)
            push_byte((((k / 3) % 2) == 0 ? mac[15:8] : mac[7:0]) ^ flip[k]);
    endtask

    // Vote one complete payload: count ones per bit position in each triple
    task automatic model_decide(input logic [95:0] pay, input int e);
        logic [7:0] c [12];
        logic [7:0] v [4];
        bit  dissent;
        int  ones;
        ev_t ev;
        for (int j = 0; j < 12; j++) c[j] = pay[95 - 8*j -: 8];
        dissent = 0;
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 8; b++) begin
                ones = int'(c[3*g][b]) + int'(c[3*g+1][b]) + int'(c[3*g+2][b]);
                v[g][b] = (ones >= 2);
                if (ones == 1 || ones == 2) dissent = 1;
            end
        end
        ev.edge_n = e;
        if ({v[0], v[1]} == {v[2], v[3]}) begin
            mdl_data  = {v[0], v[1]};
            mdl_corr  = dissent;
            ev.is_err = 0;
        end else begin
            ev.is_err = 1;
        end
        ev.data = mdl_data;
        ev.corr = mdl_corr;
        exp_ev_q.push_back(ev);
    endtask

    // Walk the bit list sample by sample: bit k is sampled at posedge pt+SP+k*BP
    task automatic model_stream(input int t0);
        int          fill;
        logic [47:0] win;
        bit          in_pay;
        int          pcnt;
        logic [95:0] pay;
        int          e;
        fill = 0; win = '0; in_pay = 0; pcnt = 0; pay = '0;
        exp_ev_q.delete();
        exp_lock_q.delete();
        for (int k = 0; k < stim_q.size(); k++) begin
            e = t0 + SP + k * BP;
            if (!in_pay) begin
                win = {win[46:0], stim_q[k]};
                if (fill < 48) fill++;
                if (fill == 48 && win == {6{PRE}}) begin
                    in_pay = 1;
                    pcnt   = 0;
                    exp_lock_q.push_back(e);
                end
            end else begin
                pay[95 - pcnt] = stim_q[k];
                pcnt++;
                if (pcnt == 96) begin
                    model_decide(pay, e + 1);
                    in_pay = 0;
                    fill   = 0;
                    win    = '0;
                end
            end
        end
    endtask

    // Called at a negedge: trigger rises, the next posedge sees counter 0
    task automatic start_stream();
        trigger = 1'b1;
        pt = edge_cnt + 1;
    endtask

    task automatic send_bits(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            rx_bit = stim_q[k];
            repeat (BP) @(negedge clock);
        end
    endtask

    task automatic run_stream();
        start_stream();
        model_stream(pt);
        send_bits(0, stim_q.size());
        repeat (3) @(negedge clock);
        trigger = 1'b0;
        rx_bit  = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic compare_logs();
        int n;
        chk("event_count", 32'(act_ev_q.size()), 32'(exp_ev_q.size()));
        n = (act_ev_q.size() < exp_ev_q.size()) ? act_ev_q.size() : exp_ev_q.size();
        for (int i = 0; i < n; i++) begin
            chk("event_cycle", 32'(act_ev_q[i].edge_n), 32'(exp_ev_q[i].edge_n));
            chk("event_is_error", 32'(act_ev_q[i].is_err), 32'(exp_ev_q[i].is_err));
            chk("event_mac_data", 32'(act_ev_q[i].data), 32'(exp_ev_q[i].data));
            chk("event_corrected", 32'(act_ev_q[i].corr), 32'(exp_ev_q[i].corr));
        end
        chk("lock_count", 32'(act_lock_q.size()), 32'(exp_lock_q.size()));
        n = (act_lock_q.size() < exp_lock_q.size()) ? act_lock_q.size() : exp_lock_q.size();
        for (int i = 0; i < n; i++)
            chk("lock_cycle", 32'(act_lock_q[i]), 32'(exp_lock_q[i]));
        chk("in_frame_fall_count", 32'(act_fall_q.size()), 32'(exp_ev_q.size()));
        n = (act_fall_q.size() < exp_ev_q.size()) ? act_fall_q.size() : exp_ev_q.size();
        for (int i = 0; i < n; i++)
            chk("in_frame_fall_cycle", 32'(act_fall_q[i]), 32'(exp_ev_q[i].edge_n));
    endtask

    function automatic int count_kind(input bit err);
        int c = 0;
        foreach (act_ev_q[i]) if (act_ev_q[i].is_err == err) c++;
        return c;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mac_data"},  32'(mac_data),  32'd0);
        chk({tag, "_mac_valid"}, 32'(mac_valid), 32'd0);
        chk({tag, "_mac_error"}, 32'(mac_error), 32'd0);
        chk({tag, "_corrected"}, 32'(corrected), 32'd0);
        chk({tag, "_in_frame"},  32'(in_frame),  32'd0);
    endtask

    vec_t tbl [4];

    initial begin
        logic [11:0][7:0] fl;
        logic [15:0]      rmac;

        tbl[0] = '{16'hA55A, 0, '0, 1, 0, 16'hA55A, 1'b0};
        tbl[1] = '{16'hA55A, 0, '0, 1, 0, 16'hA55A, 1'b1};
        tbl[1].flip[1]  = 8'h08;
        tbl[1].flip[10] = 8'h01;
        tbl[2] = '{16'h1234, 0, '0, 0, 1, 16'hA55A, 1'b1};
        tbl[2].flip[6] = 8'h01;
        tbl[2].flip[7] = 8'h01;
        tbl[3] = '{16'hBEEF, 1, '0, 1, 0, 16'hBEEF, 1'b0};

        reset = 1'b1; trigger = 1'b0; rx_bit = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Test-plan frames from the vector table
        for (int t = 0; t < 4; t++) begin
            clear_logs();
            build_frame(tbl[t].mac, tbl[t].flip, tbl[t].pre_kind, 0);
            run_stream();
            compare_logs();
            chk($sformatf("tbl%0d_valid_count", t), 32'(count_kind(0)), 32'(tbl[t].n_valid));
            chk($sformatf("tbl%0d_error_count", t), 32'(count_kind(1)), 32'(tbl[t].n_err));
            chk($sformatf("tbl%0d_mac_data", t), 32'(mac_data), 32'(tbl[t].data));
            chk($sformatf("tbl%0d_corrected", t), 32'(corrected), 32'(tbl[t].corr));
        end

        // Trigger dropped for one cycle during payload bit 40
        clear_logs();
        build_frame(16'h0F0F, '0, 0, 0);
        start_stream();
        send_bits(0, 48 + 40);
        rx_bit = stim_q[48 + 40];
        repeat (2) @(negedge clock);
        trigger = 1'b0;
        @(negedge clock);
        chk("abort_in_frame", 32'(in_frame), 32'd0);
        chk("abort_no_pulse", 32'(act_ev_q.size()), 32'd0);
        chk("abort_lock_seen", 32'(act_lock_q.size()), 32'd1);
        clear_logs();
        run_stream();
        compare_logs();
        chk("resend_valid_count", 32'(count_kind(0)), 32'd1);
        chk("resend_mac_data", 32'(mac_data), 32'h0F0F);

        // Reset during payload bit 95, before its sample point
        clear_logs();
        build_frame(16'h5A5A, '0, 0, 0);
        start_stream();
        send_bits(0, 48 + 95);
        rx_bit = stim_q[48 + 95];
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_outputs_zero("mid_reset");
        repeat (BP) @(negedge clock);
        reset = 1'b0;
        trigger = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_reset_no_pulse", 32'(act_ev_q.size()), 32'd0);
        mdl_data = '0;
        mdl_corr = 1'b0;
        clear_logs();
        build_frame(16'h3C3C, '0, 0, 0);
        run_stream();
        compare_logs();
        chk("post_reset_mac_data", 32'(mac_data), 32'h3C3C);

        // Randomized frames with leading noise and sparse bit flips
        for (int r = 0; r < 6; r++) begin
            rmac = 16'($urandom);
            fl = '0;
            for (int k = 0; k < 12; k++)
                if ($urandom_range(0, 3) == 0) fl[k] = 8'(1 << $urandom_range(0, 7));
            clear_logs();
            build_frame(rmac, fl, 0, int'($urandom_range(0, 20)));
            run_stream();
            compare_logs();
            chk("rand_mac_data_hold", 32'(mac_data), 32'(mdl_data));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
